// File: rtl/slice_sequencer_if.sv
// Handshake bundle for slice_sequencer: wide-word input side and narrow slice output side.
interface slice_sequencer_if #(
  parameter int INPUT_DATA_WIDTH = 32,
  parameter int SLICE_WIDTH      = 8
);
  localparam int NUM_SLICES = INPUT_DATA_WIDTH / SLICE_WIDTH;
  localparam int IDX_W      = ($clog2(NUM_SLICES) > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int CNT_W      = $clog2(NUM_SLICES + 1);

  logic [INPUT_DATA_WIDTH-1:0] in_data;
  logic [CNT_W-1:0]            in_count;
  logic                        in_valid;
  logic                        in_ready;
  logic [SLICE_WIDTH-1:0]      out_data;
  logic [IDX_W-1:0]            out_index;
  logic                        out_last;
  logic                        out_valid;
  logic                        out_ready;
  logic                        busy;

  // Upstream/downstream environment view
  modport master (
    output in_data, in_count, in_valid, out_ready,
    input  in_ready, out_data, out_index, out_last, out_valid, busy
  );

  // Sequencer view
  modport slave (
    input  in_data, in_count, in_valid, out_ready,
    output in_ready, out_data, out_index, out_last, out_valid, busy
  );
endinterface

// File: rtl/slice_sequencer.sv
// slice_sequencer: holds one wide word and emits it as SLICE_WIDTH slices,
// one per output handshake, MSB-first or LSB-first, with index and last flag.
module slice_sequencer #(
  parameter     BLOCK_NAME       = "slice_sequencer",
  parameter int X                = 0,
  parameter int Y                = 0,
  parameter int DX               = 0,
  parameter int DY               = 0,
  parameter int INPUT_DATA_WIDTH = 32,
  parameter int SLICE_WIDTH      = 8,
  parameter int MSB_FIRST        = 1
) (
  input logic             clk,
  input logic             rst_n,
  slice_sequencer_if.slave bus
);
  localparam int NUM_SLICES = INPUT_DATA_WIDTH / SLICE_WIDTH;
  localparam int IDX_W      = ($clog2(NUM_SLICES) > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int CNT_W      = $clog2(NUM_SLICES + 1);
  localparam logic [CNT_W-1:0] NUM_CNT = CNT_W'(NUM_SLICES);

  // Placement and naming parameters only label the block in diagrams
  localparam int unused_diagram_pos = X + Y + DX + DY;
  localparam int unused_name_bits   = $bits(BLOCK_NAME);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]                  state_q, state_d;
  logic [INPUT_DATA_WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0]            remain_q, remain_d;
  logic [SLICE_WIDTH-1:0]      out_data_q, out_data_d;
  logic [IDX_W-1:0]            out_index_q, out_index_d;
  logic                        out_last_q, out_last_d;

  logic                        out_hs;
  logic                        last_hs;
  logic                        in_ready;
  logic                        accept;
  logic [CNT_W-1:0]            eff_count;
  logic [INPUT_DATA_WIDTH-1:0] work_next;

  // The slice at the head of the working register in the configured order
  function automatic logic [SLICE_WIDTH-1:0] head_slice(input logic [INPUT_DATA_WIDTH-1:0] word);
    if (MSB_FIRST != 0) return word[INPUT_DATA_WIDTH-1 -: SLICE_WIDTH];
    else                return word[SLICE_WIDTH-1:0];
  endfunction

  // Handshake decode, clamped count and the shifted working word
  always_comb begin
    out_hs    = (state_q == ST_SHIFT) && bus.out_ready;
    last_hs   = out_hs && out_last_q;
    in_ready  = (state_q == ST_IDLE) || last_hs;
    accept    = bus.in_valid && in_ready;
    eff_count = ((bus.in_count == '0) || (bus.in_count > NUM_CNT)) ? NUM_CNT : bus.in_count;
    work_next = (MSB_FIRST != 0) ? (work_q << SLICE_WIDTH) : (work_q >> SLICE_WIDTH);
  end

  // Next-state: load on accept, advance on a non-last handshake, drop to idle after the last one
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    remain_d    = remain_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    if (accept) begin
      state_d     = ST_SHIFT;
      work_d      = bus.in_data;
      remain_d    = eff_count;
      out_data_d  = head_slice(bus.in_data);
      out_index_d = '0;
      out_last_d  = (eff_count == CNT_W'(1));
    end else if (last_hs) begin
      state_d     = ST_IDLE;
      remain_d    = '0;
      out_index_d = '0;
      out_last_d  = 1'b0;
    end else if (out_hs) begin
      work_d      = work_next;
      remain_d    = remain_q - CNT_W'(1);
      out_data_d  = head_slice(work_next);
      out_index_d = out_index_q + IDX_W'(1);
      out_last_d  = (remain_q == CNT_W'(2));
    end
  end

  // State and datapath registers; reset discards any held word at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      remain_q    <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      remain_q    <= remain_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
    end
  end

  // Drive the bundle; only in_ready is combinational
  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_data  = out_data_q;
    bus.out_index = out_index_q;
    bus.out_last  = out_last_q;
    bus.out_valid = (state_q == ST_SHIFT);
    bus.busy      = (state_q == ST_SHIFT);
  end
endmodule

// File: tb/tb_slice_sequencer.sv
// Directed bench for slice_sequencer: a vector table for single words in both
// slice orders, plus hand-written backpressure, back-to-back and mid-word reset sequences.
module tb_slice_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  slice_sequencer_if bus_m ();
  slice_sequencer_if bus_l ();

  slice_sequencer #(.MSB_FIRST(1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(bus_m));
  slice_sequencer #(.MSB_FIRST(0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l));

  logic        cur_sel;
  logic [31:0] drv_data;
  logic [2:0]  drv_count;
  logic        drv_valid;
  logic        drv_ready;

  assign bus_m.in_data   = drv_data;
  assign bus_l.in_data   = drv_data;
  assign bus_m.in_count  = drv_count;
  assign bus_l.in_count  = drv_count;
  assign bus_m.in_valid  = drv_valid & cur_sel;
  assign bus_l.in_valid  = drv_valid & ~cur_sel;
  assign bus_m.out_ready = drv_ready;
  assign bus_l.out_ready = drv_ready;

  logic [7:0] mon_data;
  logic [1:0] mon_index;
  logic       mon_last, mon_valid, mon_in_ready, mon_busy;
  assign mon_data     = cur_sel ? bus_m.out_data  : bus_l.out_data;
  assign mon_index    = cur_sel ? bus_m.out_index : bus_l.out_index;
  assign mon_last     = cur_sel ? bus_m.out_last  : bus_l.out_last;
  assign mon_valid    = cur_sel ? bus_m.out_valid : bus_l.out_valid;
  assign mon_in_ready = cur_sel ? bus_m.in_ready  : bus_l.in_ready;
  assign mon_busy     = cur_sel ? bus_m.busy      : bus_l.busy;

  typedef struct {
    logic        sel;
    logic [31:0] data;
    logic [2:0]  count;
    logic [31:0] exp_slices;
    int          exp_n;
  } vec_t;

  vec_t vecs [7];
  int n_checks = 0;
  int n_errors = 0;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One word with out_ready held high; slice k expected at exp_slices[31-8k -: 8]
  task automatic apply_stimulus(input vec_t v, input int vi);
    logic [31:0] exp_word;
    exp_word  = v.exp_slices;
    cur_sel   = v.sel;
    drv_data  = v.data;
    drv_count = v.count;
    drv_valid = 1'b1;
    drv_ready = 1'b1;
    #1;
    check_output($sformatf("v%0d_in_ready_idle", vi), 32'(mon_in_ready), 32'd1);
    cycle();
    drv_valid = 1'b0;
    for (int k = 0; k < v.exp_n; k++) begin
      check_output($sformatf("v%0d_valid_%0d", vi, k), 32'(mon_valid), 32'd1);
      check_output($sformatf("v%0d_data_%0d", vi, k), 32'(mon_data), 32'(exp_word[31-8*k -: 8]));
      check_output($sformatf("v%0d_index_%0d", vi, k), 32'(mon_index), 32'(k));
      check_output($sformatf("v%0d_last_%0d", vi, k), 32'(mon_last), 32'(k == v.exp_n - 1));
      check_output($sformatf("v%0d_in_ready_%0d", vi, k), 32'(mon_in_ready), 32'(k == v.exp_n - 1));
      cycle();
    end
    check_output($sformatf("v%0d_valid_after", vi), 32'(mon_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] bp_word;
    logic [3:0]  bp_pat;
    logic [63:0] b2b_exp;
    int          k;
    int          cyc;

    vecs[0] = '{1'b1, 32'hA1B2C3D4, 3'd0, 32'hA1B2C3D4, 4};
    vecs[1] = '{1'b0, 32'hA1B2C3D4, 3'd0, 32'hD4C3B2A1, 4};
    vecs[2] = '{1'b1, 32'hA1B2C3D4, 3'd2, 32'hA1B20000, 2};
    vecs[3] = '{1'b1, 32'hA1B2C3D4, 3'd7, 32'hA1B2C3D4, 4};
    vecs[4] = '{1'b0, 32'hA1B2C3D4, 3'd1, 32'hD4000000, 1};
    vecs[5] = '{1'b0, 32'h11223344, 3'd3, 32'h44332200, 3};
    vecs[6] = '{1'b1, 32'h11223344, 3'd4, 32'h11223344, 4};

    cur_sel   = 1'b1;
    drv_data  = '0;
    drv_count = '0;
    drv_valid = 1'b0;
    drv_ready = 1'b0;
    rst_n     = 1'b0;
    cycle();
    cycle();
    check_output("rst_in_ready", 32'(mon_in_ready), 32'd1);
    check_output("rst_out_valid", 32'(mon_valid), 32'd0);
    check_output("rst_out_last", 32'(mon_last), 32'd0);
    check_output("rst_busy", 32'(mon_busy), 32'd0);
    check_output("rst_out_data", 32'(mon_data), 32'd0);
    check_output("rst_out_index", 32'(mon_index), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) apply_stimulus(vecs[i], i);

    // Backpressure: ready pattern 1,0,0,1 then random; each slice exactly once, in order
    cur_sel   = 1'b1;
    bp_word   = 32'hDEADBEEF;
    bp_pat    = 4'b1001;
    drv_data  = bp_word;
    drv_count = 3'd0;
    drv_valid = 1'b1;
    drv_ready = 1'b0;
    cycle();
    drv_valid = 1'b0;
    k   = 0;
    cyc = 0;
    while (k < 4 && cyc < 64) begin
      drv_ready = (cyc < 4) ? bp_pat[cyc] : 1'($urandom_range(0, 1));
      #1;
      check_output($sformatf("bp_valid_c%0d", cyc), 32'(mon_valid), 32'd1);
      check_output($sformatf("bp_data_c%0d", cyc), 32'(mon_data), 32'(bp_word[31-8*k -: 8]));
      check_output($sformatf("bp_index_c%0d", cyc), 32'(mon_index), 32'(k));
      check_output($sformatf("bp_last_c%0d", cyc), 32'(mon_last), 32'(k == 3));
      check_output($sformatf("bp_in_ready_c%0d", cyc), 32'(mon_in_ready), 32'((k == 3) && drv_ready));
      if (drv_ready) k++;
      cyc++;
      cycle();
    end
    check_output("bp_all_delivered", 32'(k), 32'd4);
    check_output("bp_valid_after", 32'(mon_valid), 32'd0);

    // Back-to-back words with in_valid held: second word taken with the 44 handshake
    cur_sel   = 1'b1;
    b2b_exp   = 64'h1122334455667788;
    drv_data  = 32'h11223344;
    drv_count = 3'd0;
    drv_valid = 1'b1;
    drv_ready = 1'b1;
    cycle();
    drv_data = 32'h55667788;
    #1;
    for (int j = 0; j < 8; j++) begin
      check_output($sformatf("b2b_valid_%0d", j), 32'(mon_valid), 32'd1);
      check_output($sformatf("b2b_data_%0d", j), 32'(mon_data), 32'(b2b_exp[63-8*j -: 8]));
      check_output($sformatf("b2b_index_%0d", j), 32'(mon_index), 32'(j % 4));
      check_output($sformatf("b2b_in_ready_%0d", j), 32'(mon_in_ready), 32'((j % 4) == 3));
      cycle();
      if (j == 3) drv_valid = 1'b0;
    end
    check_output("b2b_valid_after", 32'(mon_valid), 32'd0);

    // Reset after B2 has been delivered: held word is dropped asynchronously
    cur_sel   = 1'b1;
    drv_data  = 32'hA1B2C3D4;
    drv_count = 3'd0;
    drv_valid = 1'b1;
    drv_ready = 1'b1;
    cycle();
    drv_valid = 1'b0;
    check_output("mid_rst_a1", 32'(mon_data), 32'hA1);
    cycle();
    check_output("mid_rst_b2", 32'(mon_data), 32'hB2);
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_valid", 32'(mon_valid), 32'd0);
    check_output("mid_rst_in_ready", 32'(mon_in_ready), 32'd1);
    check_output("mid_rst_busy", 32'(mon_busy), 32'd0);
    check_output("mid_rst_data", 32'(mon_data), 32'd0);
    cycle();
    rst_n     = 1'b1;
    drv_data  = 32'h0F0E0D0C;
    drv_valid = 1'b1;
    cycle();
    drv_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check_output($sformatf("post_rst_data_%0d", j), 32'(mon_data), 32'(8'h0F - 8'(j)));
      check_output($sformatf("post_rst_index_%0d", j), 32'(mon_index), 32'(j));
      check_output($sformatf("post_rst_last_%0d", j), 32'(mon_last), 32'(j == 3));
      cycle();
    end
    check_output("post_rst_valid_after", 32'(mon_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/slice_sequencer.md
# slice_sequencer

- Serialises one wide input word into a stream of fixed-width slices, one slice per output handshake.
- Each accepted word is held in a working register; slices are extracted MSB-first or LSB-first and emitted with a last flag and slice index.
- Sits in front of narrow datapaths (slice/bus-width adaptation) and replaces static bit slicing wherever a wide word must be consumed piecewise under backpressure.

## Interface
Parameters:
- BLOCK_NAME, "slice_sequencer", hierarchical block name
- X / Y / DX / DY, 0, diagram positioning only; no functional effect
- INPUT_DATA_WIDTH, 32, input word width; must be an integer multiple of SLICE_WIDTH
- SLICE_WIDTH, 8, output slice width
- MSB_FIRST, 1, 1 = first slice is the top SLICE_WIDTH bits; 0 = first slice is the bottom bits
- Derived, not overridable:
  - NUM_SLICES = INPUT_DATA_WIDTH/SLICE_WIDTH (must be ≥ 2)
  - IDX_W = max(1, clog2(NUM_SLICES))
  - CNT_W = clog2(NUM_SLICES+1)

Ports:
- clk  input  1  single clock; all logic on the rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  INPUT_DATA_WIDTH  word to serialise
- in_count  input  CNT_W  number of slices to emit from this word; sampled at accept
- in_valid  input  1  in_data/in_count valid
- in_ready  output  1  block can accept a word this cycle
- out_data  output  SLICE_WIDTH  current slice (registered)
- out_index  output  IDX_W  position of current slice within the word, starting at 0
- out_last  output  1  current slice is the final one for this word
- out_valid  output  1  out_* valid
- out_ready  input  1  downstream accepts the slice
- busy  output  1  a word is held (state SHIFT)

## Operation
- States:
  - IDLE: no word held.
  - SHIFT: word held; out_valid = 1.
- Accept: in_valid && in_ready.
- In the cycle after an accept:
  - The word is loaded into the working register and the remaining counter is set to the effective count.
  - out_data is the first slice, out_index = 0, and the state is SHIFT.
- Effective count:
  - in_count = 0 or in_count > NUM_SLICES → NUM_SLICES.
  - Otherwise the effective count is in_count.
  - A partial count emits the first in_count slices in the configured order; the remaining slices are discarded.
- Slice order:
  - MSB_FIRST = 1: slice k = word[INPUT_DATA_WIDTH-1-k·SLICE_WIDTH -: SLICE_WIDTH].
  - MSB_FIRST = 0: slice k = word[k·SLICE_WIDTH +: SLICE_WIDTH].
  - Implementation: shift the working register by SLICE_WIDTH per handshake; out_data is the registered head slice.
- Output handshake (out_valid && out_ready):
  - Not last: advance to the next slice and increment out_index.
  - Last: the word is complete.
- out_last = 1 exactly when the remaining count is 1.
- in_ready = (state == IDLE) || (out_valid && out_last && out_ready). This is combinational and allows back-to-back words with no bubble.
- Last handshake with a simultaneous accept: load the new word and stay in SHIFT.
- Last handshake without an accept: go to IDLE; out_valid falls to 0 the next cycle.
- With out_valid = 1 and out_ready = 0, all out_* hold stable. The AXI-stream rule applies: out_valid must not drop before its handshake.
- Inputs are ignored whenever in_ready = 0.
- Reset state:
  - State IDLE, so in_ready = 1 during and after reset.
  - out_valid = 0, out_last = 0, busy = 0.
  - out_data = 0, out_index = 0.
  - Working register and counter cleared.
- Reset mid-word: the held word is discarded immediately (asynchronous) and no further slices are emitted.

## Timing
- Latency: accept at edge N → first slice visible with out_valid = 1 after edge N (cycle N+1).
- Throughput: with out_ready held at 1, one slice per cycle. A word with count C occupies exactly C cycles. Continuous input gives 100 % output duty with no idle cycles.
- in_ready depends combinationally on out_ready. There is no combinational path from in_valid to any output.
- All outputs except in_ready are registered.
- Reset release: the first accept is possible on the first rising edge with rst_n = 1.

## Test plan
- MSB_FIRST = 1, in_data = 0xA1B2C3D4, in_count = 0, out_ready = 1:
  - out_data A1, B2, C3, D4 on consecutive cycles; out_index 0..3; out_last only with D4.
  - in_ready = 0 during A1–C3.
- Same word, MSB_FIRST = 0: out_data D4, C3, B2, A1, with last on A1.
- Partial and clamped counts:
  - in_count = 2 → A1, B2 with last on B2; in_ready = 1 in the B2 handshake cycle.
  - in_count = 7 → clamped to 4 slices.
- Backpressure: out_ready toggles 1, 0, 0, 1, … with a random pattern. Every slice holds stable while stalled; slices are delivered exactly once and in order; no drop or duplicate.
- Back-to-back words:
  - 0x11223344 then 0x55667788 with in_valid held and out_ready = 1.
  - 8 consecutive valid cycles: 11, 22, 33, 44, 55, 66, 77, 88.
  - Second word accepted on the same edge as the 44 handshake.
- Reset mid-word: assert rst_n = 0 after B2 is delivered.
  - out_valid = 0 immediately (asynchronous); in_ready = 1.
  - After release, a new word 0x0F0E0D0C emits 0F first, with no residue of the old word.
